// File: rtl/fpu_pkg.sv
// Shared definitions for the FP issue controller: op encodings, FSM states,
// per-op latencies and watchdog sizing.
package fpu_pkg;

    typedef enum logic [2:0] {
        OP_ADD     = 3'b000,
        OP_SUB     = 3'b001,
        OP_MUL     = 3'b010,
        OP_DIV     = 3'b011,
        OP_SQRT    = 3'b100,
        OP_CVT_LD  = 3'b101,
        OP_CVT_DL  = 3'b110,
        OP_INVALID = 3'b111
    } fpu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_WAIT_DONE,
        ST_WB
    } fpu_state_e;

    localparam int LAT_ADDSUB = 3;
    localparam int LAT_MUL    = 4;
    localparam int LAT_CVT    = 2;
    localparam int LAT_W      = 3;
    localparam int WD_W       = 7;
    localparam int WD_CYCLES  = 100;

    function automatic logic is_iterative(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_SQRT);
    endfunction

    // Accept cycle and WB cycle are not counted, hence the -2.
    function automatic logic [LAT_W-1:0] lat_preload(input logic [2:0] op);
        case (op)
            OP_ADD, OP_SUB: return LAT_W'(LAT_ADDSUB - 2);
            OP_MUL:         return LAT_W'(LAT_MUL - 2);
            default:        return LAT_W'(LAT_CVT - 2);
        endcase
    endfunction

endpackage

// File: rtl/fpu_lat_counter.sv
// Loadable down-counter with zero flag; used for fixed-op latency and the
// div/sqrt watchdog.
module fpu_lat_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec && (cnt != '0))
            cnt <= cnt - W'(1);
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/fpu_issue_ctrl.sv
// FP instruction issue/writeback sequencer. Defining FPU_TIMEOUT_EN adds a
// WAIT_DONE watchdog and the timeout_err output.
module fpu_issue_ctrl
    import fpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       issue_valid,
    output logic       issue_ready,
    input  logic [2:0] fpu_op,
    input  logic [4:0] rd,
    input  logic       flush,
    output logic       unit_start,
    output logic [2:0] unit_op,
    input  logic       unit_done,
    output logic       wb_valid,
    output logic [4:0] wb_rd,
    output logic       wb_int,
    output logic       busy,
`ifdef FPU_TIMEOUT_EN
    output logic       timeout_err,
`endif
    output logic       illegal
);

    fpu_state_e state;
    logic       accept;
    logic       lat_zero;

    // issue_ready is only ever high in IDLE; flush cancels a same-cycle accept.
    assign accept = issue_valid && issue_ready && !flush;

    fpu_lat_counter #(.W(LAT_W)) u_lat (
        .clk      (clk),
        .rst      (rst),
        .load     (accept && !is_iterative(fpu_op) && (fpu_op != OP_INVALID)),
        .load_val (lat_preload(fpu_op)),
        .dec      (state == ST_EXEC),
        .zero     (lat_zero)
    );

`ifdef FPU_TIMEOUT_EN
    logic wd_zero;

    fpu_lat_counter #(.W(WD_W)) u_wd (
        .clk      (clk),
        .rst      (rst),
        .load     (accept && is_iterative(fpu_op)),
        .load_val (WD_W'(WD_CYCLES - 1)),
        .dec      (state == ST_WAIT_DONE),
        .zero     (wd_zero)
    );
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            issue_ready <= 1'b1;
            busy        <= 1'b0;
            unit_start  <= 1'b0;
            unit_op     <= '0;
            wb_valid    <= 1'b0;
            wb_rd       <= '0;
            wb_int      <= 1'b0;
            illegal     <= 1'b0;
`ifdef FPU_TIMEOUT_EN
            timeout_err <= 1'b0;
`endif
        end else begin
            unit_start <= 1'b0;
            wb_valid   <= 1'b0;
            illegal    <= 1'b0;
`ifdef FPU_TIMEOUT_EN
            timeout_err <= 1'b0;
`endif
            if (flush) begin
                state       <= ST_IDLE;
                issue_ready <= 1'b1;
                busy        <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (accept) begin
                            if (fpu_op == OP_INVALID) begin
                                illegal <= 1'b1;
                            end else begin
                                unit_op     <= fpu_op;
                                wb_rd       <= rd;
                                wb_int      <= (fpu_op == OP_CVT_LD);
                                unit_start  <= 1'b1;
                                issue_ready <= 1'b0;
                                busy        <= 1'b1;
                                state       <= is_iterative(fpu_op) ? ST_WAIT_DONE : ST_EXEC;
                            end
                        end
                    end
                    ST_EXEC: begin
                        if (lat_zero) begin
                            wb_valid <= 1'b1;
                            state    <= ST_WB;
                        end
                    end
                    ST_WAIT_DONE: begin
                        if (unit_done) begin
                            wb_valid <= 1'b1;
                            state    <= ST_WB;
                        end
`ifdef FPU_TIMEOUT_EN
                        else if (wd_zero) begin
                            timeout_err <= 1'b1;
                            issue_ready <= 1'b1;
                            busy        <= 1'b0;
                            state       <= ST_IDLE;
                        end
`endif
                    end
                    default: begin
                        issue_ready <= 1'b1;
                        busy        <= 1'b0;
                        state       <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed, table-driven bench for fpu_issue_ctrl plus hand sequences for
// back-to-back issue, flush, reset and (when FPU_TIMEOUT_EN) the watchdog.
module tb_fpu_issue_ctrl;

    logic       clk;
    logic       rst;
    logic       issue_valid;
    logic       issue_ready;
    logic [2:0] fpu_op;
    logic [4:0] rd;
    logic       flush;
    logic       unit_start;
    logic [2:0] unit_op;
    logic       unit_done;
    logic       wb_valid;
    logic [4:0] wb_rd;
    logic       wb_int;
    logic       busy;
    logic       illegal;
`ifdef FPU_TIMEOUT_EN
    logic       timeout_err;
`endif

    fpu_issue_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .fpu_op      (fpu_op),
        .rd          (rd),
        .flush       (flush),
        .unit_start  (unit_start),
        .unit_op     (unit_op),
        .unit_done   (unit_done),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_int      (wb_int),
        .busy        (busy),
`ifdef FPU_TIMEOUT_EN
        .timeout_err (timeout_err),
`endif
        .illegal     (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Returns #1 after a rising edge: outputs of the new cycle are settled and
    // inputs driven now are sampled at the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [2:0] op;
        logic [4:0] rd;
        int         done_cyc;
        int         exp_start;
        int         exp_wb;
        logic       exp_int;
        int         exp_ill;
        int         exp_ready;
    } vec_t;

    vec_t vecs[8];

    task automatic run_vec(input vec_t v, input int idx);
        int start_c = 0, wb_c = 0, wb_n = 0, ill_n = 0, ready_c = 0;
        logic [4:0] got_rd = '0;
        logic       got_int = 1'b0;
        logic       busy1 = 1'b0;
        fpu_op      = v.op;
        rd          = v.rd;
        issue_valid = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            tick();
            issue_valid = 1'b0;
            unit_done   = (c == v.done_cyc);
            if (unit_start && start_c == 0) start_c = c;
            if (wb_valid) begin
                wb_n++;
                wb_c    = c;
                got_rd  = wb_rd;
                got_int = wb_int;
            end
            if (illegal) ill_n++;
            if (issue_ready && ready_c == 0) ready_c = c;
            if (c == 1) busy1 = busy;
        end
        unit_done = 1'b0;
        chk($sformatf("v%0d_start_cyc", idx), start_c, v.exp_start);
        chk($sformatf("v%0d_wb_cyc", idx), wb_c, v.exp_wb);
        chk($sformatf("v%0d_wb_count", idx), wb_n, (v.exp_wb != 0) ? 1 : 0);
        chk($sformatf("v%0d_illegal_count", idx), ill_n, v.exp_ill);
        chk($sformatf("v%0d_ready_cyc", idx), ready_c, v.exp_ready);
        chk($sformatf("v%0d_busy_c1", idx), busy1, (v.op != 3'b111) ? 1 : 0);
        if (v.exp_wb != 0) begin
            chk($sformatf("v%0d_wb_rd", idx), got_rd, v.rd);
            chk($sformatf("v%0d_wb_int", idx), got_int, v.exp_int);
            chk($sformatf("v%0d_unit_op_held", idx), unit_op, v.op);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int s1, s2, sn, wn;
        //           op      rd  done start wb int ill ready
        vecs[0] = '{3'b000,  1,  1,   1,   3, 0,  0,  4};
        vecs[1] = '{3'b001,  2,  0,   1,   3, 0,  0,  4};
        vecs[2] = '{3'b010, 21,  0,   1,   4, 0,  0,  5};
        vecs[3] = '{3'b011, 30, 12,   1,  13, 0,  0, 14};
        vecs[4] = '{3'b100,  7,  7,   1,   8, 0,  0,  9};
        vecs[5] = '{3'b101, 19,  2,   1,   2, 1,  0,  3};
        vecs[6] = '{3'b110,  5,  0,   1,   2, 0,  0,  3};
        vecs[7] = '{3'b111,  9,  1,   0,   0, 0,  1,  1};

        rst = 1'b1; issue_valid = 1'b0; fpu_op = '0; rd = '0;
        flush = 1'b0; unit_done = 1'b0;
        tick(); tick();
        chk("rst_issue_ready", issue_ready, 1);
        chk("rst_unit_start", unit_start, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_unit_op", unit_op, 0);
        chk("rst_wb_rd", wb_rd, 0);
        chk("rst_wb_int", wb_int, 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // issue_valid held through busy: second accept only once back in IDLE
        fpu_op = 3'b010; rd = 5'd21; issue_valid = 1'b1;
        s1 = 0; s2 = 0; sn = 0;
        for (int c = 1; c <= 7; c++) begin
            tick();
            if (unit_start) begin
                sn++;
                if (s1 == 0) s1 = c; else s2 = c;
            end
        end
        issue_valid = 1'b0;
        chk("b2b_start_count", sn, 2);
        chk("b2b_first_start", s1, 1);
        chk("b2b_second_start", s2, 6);
        for (int c = 0; c < 8; c++) tick();

        // unit_done while idle
        wn = 0;
        unit_done = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (wb_valid) wn++;
        end
        unit_done = 1'b0;
        tick();
        if (wb_valid) wn++;
        chk("idle_done_no_wb", wn, 0);

        // sqrt: flush and unit_done together in cycle 5
        fpu_op = 3'b100; rd = 5'd3; issue_valid = 1'b1;
        tick();
        issue_valid = 1'b0;
        tick(); tick(); tick();
        tick();
        flush = 1'b1; unit_done = 1'b1;
        tick();
        flush = 1'b0; unit_done = 1'b0;
        chk("flush_wb_valid_c6", wb_valid, 0);
        chk("flush_issue_ready_c6", issue_ready, 1);
        chk("flush_busy_c6", busy, 0);
        wn = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (wb_valid) wn++;
        end
        chk("flush_no_late_wb", wn, 0);

        // flush beats a simultaneous issue in IDLE
        fpu_op = 3'b000; rd = 5'd4; issue_valid = 1'b1; flush = 1'b1;
        tick();
        issue_valid = 1'b0; flush = 1'b0;
        chk("flush_vs_issue_start", unit_start, 0);
        chk("flush_vs_issue_busy", busy, 0);
        tick();

        // reset while in EXEC
        fpu_op = 3'b010; rd = 5'd11; issue_valid = 1'b1;
        tick();
        issue_valid = 1'b0;
        tick();
        chk("pre_rst_busy", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("exec_rst_issue_ready", issue_ready, 1);
        chk("exec_rst_busy", busy, 0);
        chk("exec_rst_wb_valid", wb_valid, 0);
        chk("exec_rst_unit_op", unit_op, 0);
        chk("exec_rst_wb_rd", wb_rd, 0);
        wn = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (wb_valid) wn++;
        end
        chk("exec_rst_no_wb", wn, 0);

`ifdef FPU_TIMEOUT_EN
        begin
            int to_c = 0, to_n = 0;
            fpu_op = 3'b011; rd = 5'd8; issue_valid = 1'b1;
            wn = 0;
            for (int c = 1; c <= 110; c++) begin
                tick();
                issue_valid = 1'b0;
                if (timeout_err) begin
                    to_n++;
                    if (to_c == 0) to_c = c;
                end
                if (wb_valid) wn++;
            end
            chk("timeout_cycle", to_c, 101);
            chk("timeout_count", to_n, 1);
            chk("timeout_no_wb", wn, 0);
            chk("timeout_ready_after", issue_ready, 1);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fpu_issue_ctrl.md
FPU_ISSUE_CTRL -- requirements
Module: fpu_issue_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: issue_valid  input  1  decoded FP instruction present.
REQ-004 SHALL have port: issue_ready  output  1  controller can accept an instruction.
REQ-005 SHALL have port: fpu_op  input  3  op code (000 add, 001 sub, 010 mul, 011 div, 100 sqrt, 101 fcvt.l.d, 110 fcvt.d.l, 111 invalid).
REQ-006 SHALL have port: rd  input  5  destination register index.
REQ-007 SHALL have port: flush  input  1  cancel any in-flight op.
REQ-008 SHALL have port: unit_start  output  1  one-cycle start pulse to the FPU datapath.
REQ-009 SHALL have port: unit_op  output  3  latched op driven to the datapath.
REQ-010 SHALL have port: unit_done  input  1  completion from the iterative div/sqrt unit.
REQ-011 SHALL have port: wb_valid  output  1  one-cycle writeback strobe.
REQ-012 SHALL have port: wb_rd  output  5  latched destination index.
REQ-013 SHALL have port: wb_int  output  1  destination is the integer file (1 only for fcvt.l.d).
REQ-014 SHALL have port: busy  output  1  state != IDLE; drives pipeline stall.
REQ-015 SHALL have port: illegal  output  1  one-cycle pulse on an accepted op 111.

Function
REQ-016 SHALL implement FSM states IDLE, EXEC, WAIT_DONE, WB.
REQ-017 SHALL assert issue_ready only in IDLE; accept = issue_valid && issue_ready.
REQ-018 On accepting ops 000-110, SHALL latch fpu_op/rd into unit_op/wb_rd, pulse unit_start in the next cycle, and enter EXEC (fixed-latency ops) or WAIT_DONE (div, sqrt).
REQ-019 SHALL assert wb_valid exactly L cycles after the accept cycle: L = 3 add/sub, 4 mul, 2 fcvt; the fixed-latency counter is 3 bits and is loaded with L-2 on accept.
REQ-020 For div/sqrt, SHALL assert wb_valid in the cycle after unit_done is sampled high in WAIT_DONE.
REQ-021 wb_valid SHALL last one cycle (WB state) and the FSM SHALL return to IDLE, so back-to-back accepts are L+1 cycles apart.
REQ-022 On accepting op 111, SHALL pulse illegal in the next cycle, issue no unit_start or wb_valid, and stay in IDLE.
REQ-023 unit_done outside WAIT_DONE SHALL be ignored.
REQ-024 flush SHALL return the FSM to IDLE on the next edge from any state, suppressing wb_valid; flush wins over simultaneous unit_done, counter expiry or issue_valid.
REQ-025 wb_rd, wb_int and unit_op SHALL hold their latched values until the next accept.

Reset
REQ-026 While rst is high at a clock edge: state IDLE, counter 0, and all outputs 0 except issue_ready = 1; rst SHALL override flush and issue.
REQ-027 Reset mid-operation SHALL abandon the op with no wb_valid generated afterwards.

Configuration
REQ-028 With FPU_TIMEOUT_EN defined, SHALL include a 7-bit watchdog in WAIT_DONE: after 100 cycles without unit_done it SHALL pulse output timeout_err, suppress wb_valid and return to IDLE.
REQ-029 Without FPU_TIMEOUT_EN, SHALL contain no watchdog and no timeout_err port, and WAIT_DONE SHALL wait indefinitely.

Structure
REQ-030 Op encodings, FSM state enum and per-op latency constants SHALL reside in shared package fpu_pkg.
REQ-031 The fixed-latency and watchdog counting SHALL be one sub-module, fpu_lat_counter (load, decrement, zero flag).

Verification
REQ-032 Accept fadd (000, rd=1) in cycle 0 -> unit_start in cycle 1, wb_valid in cycle 3, wb_rd=1, wb_int=0.
REQ-033 Accept fmul (010, rd=21) -> wb_valid in cycle 4; issue_valid held high during busy is not accepted until IDLE.
REQ-034 Accept fdiv (011, rd=30), unit_done at cycle 12 -> wb_valid in cycle 13; an unit_done pulse in IDLE -> no wb_valid.
REQ-035 Accept fcvt.l.d (101, rd=19) -> wb_valid in cycle 2 with wb_int=1; op 111 -> illegal pulse, no unit_start.
REQ-036 fsqrt accepted, flush and unit_done together in cycle 5 -> no wb_valid, issue_ready=1 in cycle 6; rst in EXEC -> all outputs at reset values.
REQ-037 With FPU_TIMEOUT_EN: fdiv accepted, no unit_done -> timeout_err after 100 WAIT_DONE cycles, no wb_valid.
